// File: rtl/btn_debounce_pulse_gen_pkg.sv
// Shared definitions for the push-button debounce / pulse generator:
// FSM state encodings, default timing parameters and small decode helpers.
package btn_debounce_pulse_gen_pkg;

    // State encodings are fixed so other blocks and benches can decode them.
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PRESS_CHK   = 2'b01,
        HELD        = 2'b10,
        RELEASE_CHK = 2'b11
    } state_t;

    // Default timing, reused by the counter-level top and the bench.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_REPEAT_CYCLES   = 0;
    localparam int DEFAULT_CNT_W           = 16;

    // Debounced level: the button counts as down once a press is accepted
    // and stays down until the release is confirmed.
    function automatic logic level_of(state_t s);
        return (s == HELD) || (s == RELEASE_CHK);
    endfunction

    // A stability check is running in either of the two check states.
    function automatic logic busy_of(state_t s);
        return (s == PRESS_CHK) || (s == RELEASE_CHK);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_gen_if.sv
// Button-side bundle: raw button in, conditioned pulse / level / busy out.
interface btn_debounce_pulse_gen_if;

    logic btn_in;
    logic en_pulse_out;
    logic btn_level_out;
    logic busy_out;

    // Whoever drives the raw button and consumes the conditioned outputs.
    modport master (
        output btn_in,
        input  en_pulse_out,
        input  btn_level_out,
        input  busy_out
    );

    // The conditioning block itself.
    modport slave (
        input  btn_in,
        output en_pulse_out,
        output btn_level_out,
        output busy_out
    );

endinterface

// File: rtl/btn_debounce_pulse_gen_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
// Resets to 0; output is the input delayed by two clk edges.
module btn_debounce_pulse_gen_sync_2ff (
    input  logic clk,
    input  logic reset_al_in,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability a full cycle to settle.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse_gen.sv
// Push-button conditioner: synchronizes a raw bouncing button, accepts a
// press or release only after DEBOUNCE_CYCLES stable samples, and emits one
// registered enable pulse per accepted press (plus optional auto-repeat
// pulses every REPEAT_CYCLES while held). Also drives a debounced level and
// a busy flag for status indication.
module btn_debounce_pulse_gen
    import btn_debounce_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES, // >= 2
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,   // 0 = off, else >= 2
    parameter int CNT_W           = DEFAULT_CNT_W            // 2^CNT_W > both periods
) (
    input  logic                     clk,
    input  logic                     reset_al_in,
    btn_debounce_pulse_gen_if.slave  btn_if
);

    // Terminal counts; the counters restart from 0 on every state entry,
    // so they only ever count up to these values and never wrap.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  =
        CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

    logic             btn_sync;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
    logic             pulse_d;

    logic             en_pulse_q;
    logic             level_q;
    logic             busy_q;

    // The FSM only ever looks at the synchronized copy of the button.
    btn_debounce_pulse_gen_sync_2ff u_sync (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .d           (btn_if.btn_in),
        .q           (btn_sync)
    );

    // State register together with the debounce and repeat counters.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
        end
    end

    // Next-state, counter update and pulse request for the coming cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end

            PRESS_CHK: begin
                if (!btn_sync) begin
                    // Bounce: the press did not stay stable long enough.
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    rpt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                if (!btn_sync) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (rpt_q == RPT_LAST) begin
                        pulse_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + CNT_W'(1);
                    end
                end
            end

            RELEASE_CHK: begin
                if (btn_sync) begin
                    // Release glitch: back to held, repeat period restarts.
                    state_d = HELD;
                    rpt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                // Any corrupted encoding recovers to IDLE with quiet outputs.
                state_d = IDLE;
                cnt_d   = '0;
                rpt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with the state register and never glitch.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            en_pulse_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            en_pulse_q <= pulse_d;
            level_q    <= level_of(state_d);
            busy_q     <= busy_of(state_d);
        end
    end

    assign btn_if.en_pulse_out  = en_pulse_q;
    assign btn_if.btn_level_out = level_q;
    assign btn_if.busy_out      = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse_gen.sv
// Bench for btn_debounce_pulse_gen: two instances share one button, one
// without auto-repeat and one repeating every 6 cycles. Directed scenarios
// check fixed timings; a random bouncing phase is compared against a
// run-length reference model of the debounce rules.
module tb_btn_debounce_pulse_gen;

    localparam int DB    = 4;
    localparam int RPT_B = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;

    int total = 0;
    int bad   = 0;

    btn_debounce_pulse_gen_if if0 ();
    btn_debounce_pulse_gen_if if6 ();

    assign if0.btn_in = btn;
    assign if6.btn_in = btn;

    btn_debounce_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(0), .CNT_W(8)) u_dut0 (
        .clk         (clk),
        .reset_al_in (rst_n),
        .btn_if      (if0)
    );

    btn_debounce_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RPT_B), .CNT_W(8)) u_dut6 (
        .clk         (clk),
        .reset_al_in (rst_n),
        .btn_if      (if6)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. Rules: the value the logic sees at an edge is the
    // button as sampled two edges earlier. The accepted level flips once
    // DB+1 consecutive samples disagree with it (a press fires a pulse).
    // While accepted-down and undisturbed, every RPT samples yield another
    // pulse; a disagreeing run that is abandoned restarts that period.
    // ------------------------------------------------------------------
    logic m_s1, m_s2;
    logic m_level [2];
    logic m_pulse [2];
    logic m_busy  [2];
    int   m_run   [2];
    int   m_rep   [2];

    function automatic int rpt_of(int k);
        return (k == 0) ? 0 : RPT_B;
    endfunction

    always @(posedge clk or negedge rst_n) begin : ref_model
        logic samp;
        logic lvl;
        logic pls;
        int   run;
        int   rep;
        if (!rst_n) begin
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_level[k] <= 1'b0;
                m_pulse[k] <= 1'b0;
                m_busy[k]  <= 1'b0;
                m_run[k]   <= 0;
                m_rep[k]   <= 0;
            end
        end else begin
            samp = m_s2;
            m_s1 <= btn;
            m_s2 <= m_s1;
            for (int k = 0; k < 2; k++) begin
                lvl = m_level[k];
                run = m_run[k];
                rep = m_rep[k];
                pls = 1'b0;
                if (samp != lvl) begin
                    run = run + 1;
                    if (run == DB + 1) begin
                        lvl = samp;
                        run = 0;
                        rep = 0;
                        pls = samp;
                    end
                end else if (run != 0) begin
                    run = 0;
                    rep = 0;
                end else if (lvl && rpt_of(k) != 0) begin
                    rep = rep + 1;
                    if (rep == rpt_of(k)) begin
                        rep = 0;
                        pls = 1'b1;
                    end
                end
                m_level[k] <= lvl;
                m_pulse[k] <= pls;
                m_busy[k]  <= (run != 0);
                m_run[k]   <= run;
                m_rep[k]   <= rep;
            end
        end
    end

    task automatic go_idle(int n);
        @(negedge clk);
        btn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (if0.en_pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", if0.en_pulse_out); end
        total++; if (if0.btn_level_out !== 1'b0) begin bad++; $display("FAIL reset_level got=%b exp=0", if0.btn_level_out); end
        total++; if (if0.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if0.busy_out); end
        total++; if (if6.en_pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse_r6 got=%b exp=0", if6.en_pulse_out); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (if0.btn_level_out !== 1'b0) begin bad++; $display("FAIL idle_level got=%b exp=0", if0.btn_level_out); end
    endtask

    task automatic test_clean_press;
        int first = -1;
        int npulse = 0;
        logic lv6 = 1'bx, lv7 = 1'bx, bz3 = 1'bx;
        @(negedge clk);
        btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (if0.en_pulse_out === 1'b1) begin
                npulse++;
                if (first < 0) first = e;
            end
            if (e == 3) bz3 = if0.busy_out;
            if (e == 6) lv6 = if0.btn_level_out;
            if (e == 7) lv7 = if0.btn_level_out;
        end
        total++; if (first != 7) begin bad++; $display("FAIL press_latency got_edge=%0d exp_edge=7", first); end
        total++; if (npulse != 1) begin bad++; $display("FAIL press_pulse_count got=%0d exp=1", npulse); end
        total++; if (lv6 !== 1'b0) begin bad++; $display("FAIL press_level_e6 got=%b exp=0", lv6); end
        total++; if (lv7 !== 1'b1) begin bad++; $display("FAIL press_level_e7 got=%b exp=1", lv7); end
        total++; if (bz3 !== 1'b1) begin bad++; $display("FAIL press_busy_e3 got=%b exp=1", bz3); end
    endtask

    // Starts in HELD with the button down.
    task automatic test_release_bounce;
        int fall = -1;
        int npulse = 0;
        logic lv5 = 1'bx, bz4 = 1'bx;
        @(negedge clk);
        btn = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (if0.en_pulse_out === 1'b1) npulse++;
            if (fall < 0 && if0.btn_level_out === 1'b0) fall = e;
            if (e == 4) bz4 = if0.busy_out;
            if (e == 5) lv5 = if0.btn_level_out;
            if (e == 2) btn = 1'b1;
            else if (e == 3) btn = 1'b0;
        end
        total++; if (fall != 10) begin bad++; $display("FAIL release_fall got_edge=%0d exp_edge=10", fall); end
        total++; if (npulse != 0) begin bad++; $display("FAIL release_pulses got=%0d exp=0", npulse); end
        total++; if (lv5 !== 1'b1) begin bad++; $display("FAIL release_glitch_level got=%b exp=1", lv5); end
        total++; if (bz4 !== 1'b1) begin bad++; $display("FAIL release_busy_e4 got=%b exp=1", bz4); end
    endtask

    task automatic test_press_bounce;
        int first = -1;
        int npulse = 0;
        go_idle(6);
        btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (if0.en_pulse_out === 1'b1) begin
                npulse++;
                if (first < 0) first = e;
            end
            if (e == 2) btn = 1'b0;
            else if (e == 3) btn = 1'b1;
        end
        total++; if (first != 10) begin bad++; $display("FAIL bounce_latency got_edge=%0d exp_edge=10", first); end
        total++; if (npulse != 1) begin bad++; $display("FAIL bounce_pulse_count got=%0d exp=1", npulse); end
    endtask

    task automatic test_auto_repeat;
        int pe [16];
        int n = 0;
        int n0 = 0;
        int after = 0;
        go_idle(12);
        btn = 1'b1;
        for (int e = 1; e <= 37; e++) begin
            @(posedge clk); #1;
            if (if6.en_pulse_out === 1'b1 && n < 16) begin
                pe[n] = e;
                n++;
            end
            if (if0.en_pulse_out === 1'b1) n0++;
        end
        btn = 1'b0;
        for (int e = 38; e <= 60; e++) begin
            @(posedge clk); #1;
            if (if6.en_pulse_out === 1'b1) after++;
        end
        total++; if (n != 6) begin bad++; $display("FAIL repeat_count got=%0d exp=6", n); end
        if (n > 0) begin
            total++; if (pe[0] != 7) begin bad++; $display("FAIL repeat_first got_edge=%0d exp_edge=7", pe[0]); end
        end
        for (int j = 1; j < n; j++) begin
            total++;
            if (pe[j] - pe[j-1] != RPT_B) begin
                bad++; $display("FAIL repeat_gap%0d got=%0d exp=%0d", j, pe[j] - pe[j-1], RPT_B);
            end
        end
        total++; if (n0 != 1) begin bad++; $display("FAIL repeat_off_count got=%0d exp=1", n0); end
        total++; if (after != 0) begin bad++; $display("FAIL repeat_after_release got=%0d exp=0", after); end
        total++; if (if6.btn_level_out !== 1'b0) begin bad++; $display("FAIL repeat_release_level got=%b exp=0", if6.btn_level_out); end
    endtask

    task automatic test_reset_mid;
        int first = -1;
        int npulse = 0;
        go_idle(10);
        btn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
        end
        total++; if (if0.busy_out !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", if0.busy_out); end
        rst_n = 1'b0;
        #1;
        total++; if (if0.busy_out !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", if0.busy_out); end
        total++; if (if0.btn_level_out !== 1'b0) begin bad++; $display("FAIL midrst_level got=%b exp=0", if0.btn_level_out); end
        total++; if (if0.en_pulse_out !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%b exp=0", if0.en_pulse_out); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (if0.en_pulse_out === 1'b1) begin
                npulse++;
                if (first < 0) first = e;
            end
        end
        total++; if (first != 7) begin bad++; $display("FAIL midrst_latency got_edge=%0d exp_edge=7", first); end
        total++; if (npulse != 1) begin bad++; $display("FAIL midrst_pulse_count got=%0d exp=1", npulse); end
    endtask

    task automatic test_count_chain;
        logic [1:0] ctr = 2'd0;
        int npulse = 0;
        go_idle(12);
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            btn = 1'b1;
            for (int e = 0; e < 30; e++) begin
                @(posedge clk); #1;
                if (if0.en_pulse_out === 1'b1) begin
                    ctr = ctr + 2'd1;
                    npulse++;
                end
                if (e == 14) btn = 1'b0;
            end
            total++;
            if (int'(ctr) != (p + 1) % 4) begin
                bad++; $display("FAIL chain_count_p%0d got=%0d exp=%0d", p, ctr, (p + 1) % 4);
            end
        end
        total++; if (npulse != 5) begin bad++; $display("FAIL chain_pulses got=%0d exp=5", npulse); end
    endtask

    task automatic test_random(int ncyc);
        int   hold = 0;
        logic prev0 = 1'b0;
        logic prev6 = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            total++; if (if0.en_pulse_out !== m_pulse[0]) begin bad++; $display("FAIL rand_pulse_r0 cyc=%0d got=%b exp=%b", i, if0.en_pulse_out, m_pulse[0]); end
            total++; if (if0.btn_level_out !== m_level[0]) begin bad++; $display("FAIL rand_level_r0 cyc=%0d got=%b exp=%b", i, if0.btn_level_out, m_level[0]); end
            total++; if (if0.busy_out !== m_busy[0]) begin bad++; $display("FAIL rand_busy_r0 cyc=%0d got=%b exp=%b", i, if0.busy_out, m_busy[0]); end
            total++; if (if6.en_pulse_out !== m_pulse[1]) begin bad++; $display("FAIL rand_pulse_r6 cyc=%0d got=%b exp=%b", i, if6.en_pulse_out, m_pulse[1]); end
            total++; if (if6.btn_level_out !== m_level[1]) begin bad++; $display("FAIL rand_level_r6 cyc=%0d got=%b exp=%b", i, if6.btn_level_out, m_level[1]); end
            total++; if (if6.busy_out !== m_busy[1]) begin bad++; $display("FAIL rand_busy_r6 cyc=%0d got=%b exp=%b", i, if6.busy_out, m_busy[1]); end
            total++; if (prev0 && if0.en_pulse_out) begin bad++; $display("FAIL rand_double_pulse_r0 cyc=%0d got=1 exp=0", i); end
            total++; if (prev6 && if6.en_pulse_out) begin bad++; $display("FAIL rand_double_pulse_r6 cyc=%0d got=1 exp=0", i); end
            prev0 = if0.en_pulse_out;
            prev6 = if6.en_pulse_out;
            if (hold == 0) begin
                btn  = ~btn;
                hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 40))
                                                   : int'($urandom_range(1, 5));
            end
            hold--;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_press_bounce();
        test_auto_repeat();
        test_reset_mid();
        test_count_chain();
        test_random(2000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
